// File: rtl/chicken_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : chicken_pkg
//  Description : Shared definitions for the Chicken Cha-Cha-Cha game core.
//                Holds the turn sequencer state encoding, the default track
//                length shared with the tile generator and compare datapath,
//                and width helpers used by the sequencer and its interface.
//  Revision    : 1.0 - initial release
// ============================================================================
package chicken_pkg;

    // Default number of tiles on the track (shared across the game core).
    localparam int TRACK_LEN_DEFAULT = 24;

    // Turn sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_KEY = 3'd1,
        ST_CMP      = 3'd2,
        ST_ADVANCE  = 3'd3,
        ST_PASS     = 3'd4,
        ST_WIN      = 3'd5
    } seq_state_t;

    // Player-id width: $clog2 of the player count, never below one bit.
    function automatic int pid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Position width: must hold the value TRACK_LEN itself.
    function automatic int pos_width(input int len);
        return $clog2(len + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/turn_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : turn_sequencer_if
//  Description : Bundle of board/key/compare/status signals between the turn
//                sequencer and the rest of the game core.
//                modport master : the sequencer side
//                modport slave  : the environment (tile generator, keys,
//                                 compare datapath, display)
//  Ports       : rand_done, key, cmp_done, cmp_match   (into sequencer)
//                cmp_req, cmp_player, cmp_pos, flip_en, turn, pos_flat,
//                timeout, winner_valid, winner         (out of sequencer)
//  Revision    : 1.0 - initial release
// ============================================================================
interface turn_sequencer_if
    import chicken_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int TRACK_LEN   = TRACK_LEN_DEFAULT
);
    localparam int PID_W = pid_width(NUM_PLAYERS);
    localparam int POS_W = pos_width(TRACK_LEN);

    logic                         rand_done;
    logic [NUM_PLAYERS-1:0]       key;
    logic                         cmp_req;
    logic [PID_W-1:0]             cmp_player;
    logic [POS_W-1:0]             cmp_pos;
    logic                         cmp_done;
    logic                         cmp_match;
    logic                         flip_en;
    logic [PID_W-1:0]             turn;
    logic [NUM_PLAYERS*POS_W-1:0] pos_flat;
    logic                         timeout;
    logic                         winner_valid;
    logic [PID_W-1:0]             winner;

    modport master (
        input  rand_done, key, cmp_done, cmp_match,
        output cmp_req, cmp_player, cmp_pos, flip_en, turn, pos_flat,
               timeout, winner_valid, winner
    );

    modport slave (
        output rand_done, key, cmp_done, cmp_match,
        input  cmp_req, cmp_player, cmp_pos, flip_en, turn, pos_flat,
               timeout, winner_valid, winner
    );

endinterface
`default_nettype wire

// File: rtl/turn_timer.sv
`default_nettype none
// ============================================================================
//  Module      : turn_timer
//  Description : Idle-turn timer. Cleared by load_i, counts while en_i is
//                high and raises expire_o during the CYC-th enabled cycle
//                after the last load.
//  Ports       : CLK, RST (sync, active-high), load_i, en_i, expire_o
//  Revision    : 1.0 - initial release
// ============================================================================
module turn_timer #(
    parameter int CYC = 50_000_000
) (
    input  wire logic CLK,
    input  wire logic RST,
    input  wire logic load_i,
    input  wire logic en_i,
    output logic      expire_o
);
    localparam int              CNT_W = (CYC > 1) ? $clog2(CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYC - 1);

    logic [CNT_W-1:0] cnt_q;

    // The count parks at LAST; the owner leaves the enabled state on expiry.
    always_ff @(posedge CLK) begin
        if (RST || load_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire_o = en_i && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/turn_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : turn_sequencer
//  Description : Multi-player turn scheduler. Waits for board generation,
//                hands the flip/compare datapath to one player at a time,
//                advances the active player on a match, passes the turn on a
//                mismatch and declares the winner at the end of the track.
//  Ports       : CLK, RST (sync, active-high), bus (turn_sequencer_if.master)
//  Options     : TURN_TIMEOUT_EN - when defined, a player idle in WAIT_KEY
//                for TIMEOUT_CYC cycles loses the turn (timeout pulse).
//  Revision    : 1.0 - initial release
// ============================================================================
module turn_sequencer
    import chicken_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int TRACK_LEN   = TRACK_LEN_DEFAULT,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  wire logic           CLK,
    input  wire logic           RST,
    turn_sequencer_if.master    bus
);
    localparam int               PID_W     = pid_width(NUM_PLAYERS);
    localparam int               POS_W     = pos_width(TRACK_LEN);
    localparam logic [PID_W-1:0] LAST_PID  = PID_W'(NUM_PLAYERS - 1);
    localparam logic [POS_W-1:0] TRACK_POS = POS_W'(TRACK_LEN);

    seq_state_t                   state_q, state_d;
    logic [PID_W-1:0]             turn_q, turn_d;
    logic [PID_W-1:0]             winner_q, winner_d;
    logic [NUM_PLAYERS*POS_W-1:0] pos_q, pos_d;
    logic [POS_W-1:0]             w_cur_pos;
    logic                         w_expire;

    // Position of the active player, straight from registers.
    assign w_cur_pos = pos_q[int'(turn_q)*POS_W +: POS_W];

`ifdef TURN_TIMEOUT_EN
    logic timeout_q, timeout_d;
    logic w_timer_load;

    // Counter restarts on every entry into WAIT_KEY (from IDLE, ADVANCE
    // or PASS).
    assign w_timer_load = (state_d == ST_WAIT_KEY) && (state_q != ST_WAIT_KEY);

    turn_timer #(
        .CYC      (TIMEOUT_CYC)
    ) u_turn_timer (
        .CLK      (CLK),
        .RST      (RST),
        .load_i   (w_timer_load),
        .en_i     (state_q == ST_WAIT_KEY),
        .expire_o (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            turn_q    <= '0;
            winner_q  <= '0;
            pos_q     <= '0;
`ifdef TURN_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            turn_q    <= turn_d;
            winner_q  <= winner_d;
            pos_q     <= pos_d;
`ifdef TURN_TIMEOUT_EN
            timeout_q <= timeout_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        turn_d    = turn_q;
        winner_d  = winner_q;
        pos_d     = pos_q;
`ifdef TURN_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.rand_done) begin
                    state_d = ST_WAIT_KEY;
                end
            end
            ST_WAIT_KEY: begin
                // Own key beats an expiring timer in the same cycle.
                if (bus.key[turn_q]) begin
                    state_d = ST_CMP;
                end else if (w_expire) begin
                    state_d = ST_PASS;
`ifdef TURN_TIMEOUT_EN
                    timeout_d = 1'b1;
`endif
                end
            end
            ST_CMP: begin
                if (bus.cmp_done) begin
                    state_d = bus.cmp_match ? ST_ADVANCE : ST_PASS;
                end
            end
            ST_ADVANCE: begin
                if (w_cur_pos != TRACK_POS) begin
                    pos_d[int'(turn_q)*POS_W +: POS_W] = w_cur_pos + 1'b1;
                end
                if ((w_cur_pos + 1'b1) >= TRACK_POS) begin
                    state_d  = ST_WIN;
                    winner_d = turn_q;
                end else begin
                    state_d  = ST_WAIT_KEY;
                end
            end
            ST_PASS: begin
                turn_d  = (turn_q == LAST_PID) ? '0 : turn_q + 1'b1;
                state_d = ST_WAIT_KEY;
            end
            ST_WIN: begin
                state_d = ST_WIN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from state or taken directly from registers
    // ------------------------------------------------------------------
    assign bus.cmp_req      = (state_q == ST_CMP);
    assign bus.flip_en      = (state_q == ST_WAIT_KEY);
    assign bus.winner_valid = (state_q == ST_WIN);
    assign bus.cmp_player   = turn_q;
    assign bus.cmp_pos      = w_cur_pos;
    assign bus.turn         = turn_q;
    assign bus.pos_flat     = pos_q;
    assign bus.winner       = winner_q;
`ifdef TURN_TIMEOUT_EN
    assign bus.timeout      = timeout_q;
`else
    assign bus.timeout      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_turn_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_turn_sequencer
//  Description : Self-checking bench for turn_sequencer (3 players, track of
//                4 tiles). Directed cycle table, directed win / reset /
//                timeout sequences and randomized games against a
//                rules-level model of positions and turn order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_turn_sequencer;
    import chicken_pkg::*;

    localparam int NP    = 3;
    localparam int TL    = 4;
    localparam int TO    = 10;
    localparam int POS_W = pos_width(TL);

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    turn_sequencer_if #(.NUM_PLAYERS(NP), .TRACK_LEN(TL)) bus ();

    turn_sequencer #(
        .NUM_PLAYERS (NP),
        .TRACK_LEN   (TL),
        .TIMEOUT_CYC (TO)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Rules-level model of the game.
    int m_pos [NP];
    int m_turn;
    bit m_won;

    typedef struct {
        logic          rd;
        logic [NP-1:0] key;
        logic          cd;
        logic          cm;
        logic          e_flip;
        logic          e_req;
        int            e_turn;
        int            p0, p1, p2;
    } vec_t;

    vec_t tbl [23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_idle();
        bus.rand_done = 1'b0;
        bus.key       = '0;
        bus.cmp_done  = 1'b0;
        bus.cmp_match = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        drive_idle();
        tick();
        tick();
        RST = 1'b0;
        for (int i = 0; i < NP; i++) m_pos[i] = 0;
        m_turn = 0;
        m_won  = 1'b0;
    endtask

    function automatic int flat3(input int a, input int b, input int c);
        return a + (b << POS_W) + (c << (2 * POS_W));
    endfunction

    function automatic int model_flat();
        int f = 0;
        for (int i = 0; i < NP; i++) f += m_pos[i] * (1 << (i * POS_W));
        return f;
    endfunction

    function automatic vec_t mk(input logic rd, input logic [NP-1:0] key, input logic cd,
                                input logic cm, input logic fl, input logic rq, input int t,
                                input int p0, input int p1, input int p2);
        vec_t v;
        v.rd = rd; v.key = key; v.cd = cd; v.cm = cm;
        v.e_flip = fl; v.e_req = rq; v.e_turn = t;
        v.p0 = p0; v.p1 = p1; v.p2 = p2;
        return v;
    endfunction

    function automatic logic [NP-1:0] noise_without(input int t);
        logic [NP-1:0] k;
        k = NP'($urandom);
        k[t] = 1'b0;
        return k;
    endfunction

    initial begin
        int  pidx, pcur, idle_n, wait_n;
        bit  match;

        drive_idle();

        //                rd key     cd cm  flip req turn p0 p1 p2
        tbl[0]  = mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        tbl[1]  = mk(1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
        tbl[2]  = mk(1'b0, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
        tbl[3]  = mk(1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
        tbl[4]  = mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
        tbl[5]  = mk(1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        tbl[6]  = mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1, 0, 0);
        tbl[7]  = mk(1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1, 0, 0);
        tbl[8]  = mk(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 0, 0);
        tbl[9]  = mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1, 0, 0);
        tbl[10] = mk(1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 0, 0);
        tbl[11] = mk(1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 0, 0);
        tbl[12] = mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1, 1, 0);
        tbl[13] = mk(1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 1, 0);
        tbl[14] = mk(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1, 1, 0);
        tbl[15] = mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1, 1, 0);
        tbl[16] = mk(1'b0, 3'b100, 1'b1, 1'b1, 1'b0, 1'b1, 2, 1, 1, 0);
        tbl[17] = mk(1'b0, 3'b011, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1, 1, 0);
        tbl[18] = mk(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1, 1, 0);
        tbl[19] = mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1, 1, 0);
        tbl[20] = mk(1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1, 1, 0);
        tbl[21] = mk(1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1, 1, 0);
        tbl[22] = mk(1'b0, 3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1, 1, 0);

        // ---------------- reset state ----------------
        do_reset();
        check("rst_cmp_req",      bus.cmp_req,      0);
        check("rst_flip_en",      bus.flip_en,      0);
        check("rst_turn",         bus.turn,         0);
        check("rst_pos_flat",     bus.pos_flat,     0);
        check("rst_timeout",      bus.timeout,      0);
        check("rst_winner_valid", bus.winner_valid, 0);
        check("rst_winner",       bus.winner,       0);

        // ---------------- directed cycle table ----------------
        for (int i = 0; i < 23; i++) begin
            bus.rand_done = tbl[i].rd;
            bus.key       = tbl[i].key;
            bus.cmp_done  = tbl[i].cd;
            bus.cmp_match = tbl[i].cm;
            tick();
            check($sformatf("tbl%0d_flip_en", i), bus.flip_en, 32'(tbl[i].e_flip));
            check($sformatf("tbl%0d_cmp_req", i), bus.cmp_req, 32'(tbl[i].e_req));
            check($sformatf("tbl%0d_turn", i),    bus.turn,    tbl[i].e_turn);
            check($sformatf("tbl%0d_pos", i),     bus.pos_flat,
                  flat3(tbl[i].p0, tbl[i].p1, tbl[i].p2));
            check($sformatf("tbl%0d_wv", i),      bus.winner_valid, 0);
            if (tbl[i].e_req) begin
                pcur = (tbl[i].e_turn == 0) ? tbl[i].p0 :
                       (tbl[i].e_turn == 1) ? tbl[i].p1 : tbl[i].p2;
                check($sformatf("tbl%0d_cmp_player", i), bus.cmp_player, tbl[i].e_turn);
                check($sformatf("tbl%0d_cmp_pos", i),    bus.cmp_pos,    pcur);
            end
        end
        drive_idle();

        // ---------------- player 1 walks to the end of the track ----------------
        do_reset();
        bus.rand_done = 1'b1; tick(); drive_idle();
        bus.key = 3'b001;     tick(); drive_idle();
        bus.cmp_done = 1'b1;  tick(); drive_idle();   // mismatch -> PASS
        tick();
        check("win_turn1", bus.turn, 1);
        for (int k = 0; k < TL; k++) begin
            bus.key = 3'b010; tick(); drive_idle();
            check($sformatf("win%0d_cmp_req", k), bus.cmp_req, 1);
            check($sformatf("win%0d_cmp_pos", k), bus.cmp_pos, k);
            bus.cmp_done = 1'b1; bus.cmp_match = 1'b1; tick(); drive_idle();
            check($sformatf("win%0d_req_drop", k), bus.cmp_req, 0);
            check($sformatf("win%0d_wv_early", k), bus.winner_valid, 0);
            tick();
            check($sformatf("win%0d_pos", k),  bus.pos_flat, flat3(0, k + 1, 0));
            check($sformatf("win%0d_flip", k), bus.flip_en,  32'(k < TL - 1));
            check($sformatf("win%0d_wv", k),   bus.winner_valid, 32'(k == TL - 1));
        end
        check("win_winner", bus.winner, 1);
        for (int i = 0; i < 5; i++) begin
            bus.rand_done = 1'b1;
            bus.key       = NP'($urandom) | 3'b010;
            bus.cmp_done  = 1'b1;
            bus.cmp_match = 1'b1;
            tick();
            check($sformatf("hold%0d_wv", i),     bus.winner_valid, 1);
            check($sformatf("hold%0d_winner", i), bus.winner,       1);
            check($sformatf("hold%0d_req", i),    bus.cmp_req,      0);
            check($sformatf("hold%0d_pos", i),    bus.pos_flat,     flat3(0, TL, 0));
        end
        drive_idle();

        // ---------------- reset during an outstanding compare ----------------
        do_reset();
        bus.rand_done = 1'b1; tick(); drive_idle();
        bus.key = 3'b001;     tick(); drive_idle();
        bus.cmp_done = 1'b1; bus.cmp_match = 1'b1; tick(); drive_idle();
        tick();
        bus.key = 3'b001;     tick(); drive_idle();
        check("rstmid_req_before", bus.cmp_req, 1);
        check("rstmid_pos_before", bus.pos_flat, flat3(1, 0, 0));
        RST = 1'b1; tick(); RST = 1'b0;
        check("rstmid_req",  bus.cmp_req,  0);
        check("rstmid_flip", bus.flip_en,  0);
        check("rstmid_pos",  bus.pos_flat, 0);
        check("rstmid_turn", bus.turn,     0);
        tick();
        check("rstmid_idle", bus.flip_en, 0);
        bus.rand_done = 1'b1; tick(); drive_idle();
        check("rstmid_restart", bus.flip_en, 1);

        // ---------------- randomized games against the rules model ----------------
        for (int g = 0; g < 6; g++) begin
            do_reset();
            idle_n = $urandom_range(0, 3);
            for (int i = 0; i < idle_n; i++) begin
                bus.key = NP'($urandom); bus.cmp_done = 1'($urandom);
                tick();
                check("rnd_idle_flip", bus.flip_en, 0);
            end
            drive_idle();
            bus.rand_done = 1'b1; tick(); drive_idle();
            for (int t = 0; t < 300 && !m_won; t++) begin
                check("rnd_flip",  bus.flip_en,  1);
                check("rnd_turn",  bus.turn,     m_turn);
                check("rnd_pos",   bus.pos_flat, model_flat());
                idle_n = $urandom_range(0, 3);
                for (int i = 0; i < idle_n; i++) begin
                    bus.key       = noise_without(m_turn);
                    bus.cmp_done  = 1'($urandom);
                    bus.cmp_match = 1'($urandom);
                    bus.rand_done = 1'($urandom);
                    tick();
                    check("rnd_wait_flip", bus.flip_en, 1);
                    check("rnd_wait_req",  bus.cmp_req, 0);
                end
                drive_idle();
                bus.key = NP'($urandom) | NP'(1 << m_turn);
                tick();
                check("rnd_req",        bus.cmp_req,    1);
                check("rnd_flip_off",   bus.flip_en,    0);
                check("rnd_cmp_player", bus.cmp_player, m_turn);
                check("rnd_cmp_pos",    bus.cmp_pos,    m_pos[m_turn]);
                check("rnd_timeout",    bus.timeout,    0);
                wait_n = $urandom_range(0, 2);
                for (int i = 0; i < wait_n; i++) begin
                    bus.key = NP'($urandom); bus.cmp_done = 1'b0;
                    bus.cmp_match = 1'($urandom);
                    tick();
                    check("rnd_req_hold", bus.cmp_req, 1);
                end
                match = ($urandom_range(0, 99) < 60);
                bus.key = NP'($urandom); bus.cmp_done = 1'b1; bus.cmp_match = match;
                tick();
                drive_idle();
                check("rnd_req_drop", bus.cmp_req, 0);
                check("rnd_flip_gap", bus.flip_en, 0);
                tick();
                if (match) begin
                    m_pos[m_turn]++;
                    if (m_pos[m_turn] == TL) m_won = 1'b1;
                end else begin
                    m_turn = (m_turn + 1) % NP;
                end
                check("rnd_upd_pos", bus.pos_flat,     model_flat());
                check("rnd_upd_wv",  bus.winner_valid, 32'(m_won));
                if (m_won) begin
                    check("rnd_winner", bus.winner, m_turn);
                end
            end
            check("rnd_game_won", 32'(m_won), 1);
        end

`ifdef TURN_TIMEOUT_EN
        // ---------------- idle turn is forced to pass ----------------
        do_reset();
        bus.rand_done = 1'b1; tick(); drive_idle();
        for (int i = 1; i < TO; i++) begin
            bus.key = 3'b100;
            tick();
            check("to_wait_flip",    bus.flip_en, 1);
            check("to_wait_timeout", bus.timeout, 0);
        end
        drive_idle();
        tick();
        check("to_pulse",      bus.timeout, 1);
        check("to_pulse_flip", bus.flip_en, 0);
        tick();
        check("to_pulse_end",  bus.timeout, 0);
        check("to_turn",       bus.turn,    1);
        check("to_flip",       bus.flip_en, 1);
        for (int i = 1; i < TO; i++) tick();
        bus.key = 3'b010;                       // own key in the expiry cycle
        tick(); drive_idle();
        check("to_key_wins_req",  bus.cmp_req, 1);
        check("to_key_wins_to",   bus.timeout, 0);
        bus.cmp_done = 1'b1; tick(); drive_idle();
        check("to_mismatch_to",   bus.timeout, 0);
        tick();
        check("to_mismatch_turn", bus.turn, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case anything above stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
